sram_mem_stage: RTL and testbench

Memory-stage controller between the execute stage and the off-chip 16-bit SRAM. It takes the ALU result of `LDR`/`STR` as a byte address and the store value, then performs one 32-bit word access as two 16-bit SRAM halfword phases. While the access is in flight it holds `ready` low so the pipeline freezes. The assembled load word is presented to write-back on `rdata`.

---
 rtl/sram_mem_stage_pkg.sv | 17 +
 rtl/sram_phase_counter.sv | 25 ++
 rtl/sram_mem_stage.sv | 94 +++++++++
 tb/tb_sram_mem_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_mem_stage_pkg.sv
// Shared widths, default memory base and FSM state encoding for the
// 16-bit SRAM memory stage.
package sram_mem_stage_pkg;

  localparam int unsigned LEN_REGISTER     = 32;
  localparam int unsigned LEN_SRAM_ADDR    = 18;
  localparam int unsigned LEN_SRAM_DATA    = 16;
  localparam int unsigned MEM_BASE_DEFAULT = 1024;

  typedef enum logic [1:0] {
    SRAM_IDLE = 2'd0,
    SRAM_LO   = 2'd1,
    SRAM_HI   = 2'd2,
    SRAM_DONE = 2'd3
  } sram_state_t;

endpackage

// File: rtl/sram_phase_counter.sv
// Counts WAIT cycles of one halfword phase. It flags the final cycle on
// last and rolls back to zero so the next phase starts fresh.
module sram_phase_counter #(
  parameter int unsigned WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  logic [2:0] cnt_reg;

  assign last = en && (cnt_reg == 3'(WAIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= last ? 3'd0 : cnt_reg + 3'd1;
    end
  end

endmodule

// File: rtl/sram_mem_stage.sv
// Memory stage: turns one 32-bit LDR/STR into two 16-bit SRAM phases
// (low half, then high half) and freezes the pipeline until done.
module sram_mem_stage
  import sram_mem_stage_pkg::*;
#(
  parameter int unsigned MEM_BASE  = MEM_BASE_DEFAULT,
  parameter int unsigned SRAM_WAIT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_r_en,
  input  logic                     mem_w_en,
  input  logic [LEN_REGISTER-1:0]  addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic [LEN_SRAM_ADDR-1:0] sram_addr,
  inout  wire  [LEN_SRAM_DATA-1:0] sram_dq,
  output logic                     sram_we_n
);

  sram_state_t              state_reg;
  logic                     is_write_reg;
  logic                     drive_reg;
  logic [LEN_SRAM_DATA-1:0] dq_out_reg;
  logic [LEN_SRAM_DATA-1:0] wdata_hi_reg;
  logic [16:0]              word;
  logic                     req;
  logic                     in_phase;
  logic                     phase_last;

  assign req      = mem_r_en | mem_w_en;
  assign ready    = ~req | (state_reg == SRAM_DONE);
  assign word     = 17'((addr - MEM_BASE) >> 2);
  assign in_phase = (state_reg == SRAM_LO) || (state_reg == SRAM_HI);
  assign sram_dq  = drive_reg ? dq_out_reg : 'z;

  sram_phase_counter #(
    .WAIT (SRAM_WAIT)
  ) u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (state_reg == SRAM_IDLE),
    .en    (in_phase),
    .last  (phase_last)
  );

  // Bus controls are registered and set up on the edge entering each phase,
  // so they are stable for the whole phase and drop together on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= SRAM_IDLE;
      is_write_reg <= 1'b0;
      drive_reg    <= 1'b0;
      dq_out_reg   <= '0;
      wdata_hi_reg <= '0;
      sram_we_n    <= 1'b1;
      sram_addr    <= '0;
      rdata        <= '0;
    end else begin
      case (state_reg)
        SRAM_IDLE: begin
          if (req) begin
            state_reg    <= SRAM_LO;
            is_write_reg <= mem_w_en;
            drive_reg    <= mem_w_en;
            sram_we_n    <= ~mem_w_en;
            sram_addr    <= {word, 1'b0};
            dq_out_reg   <= wdata[15:0];
            wdata_hi_reg <= wdata[31:16];
          end
        end
        SRAM_LO: begin
          if (phase_last) begin
            state_reg  <= SRAM_HI;
            sram_addr  <= {sram_addr[LEN_SRAM_ADDR-1:1], 1'b1};
            dq_out_reg <= wdata_hi_reg;
            if (!is_write_reg) rdata[15:0] <= sram_dq;
          end
        end
        SRAM_HI: begin
          if (phase_last) begin
            state_reg <= SRAM_DONE;
            drive_reg <= 1'b0;
            sram_we_n <= 1'b1;
            if (!is_write_reg) rdata[31:16] <= sram_dq;
          end
        end
        default: state_reg <= SRAM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_stage.sv
// Randomized self-checking bench for sram_mem_stage with a slow 16-bit SRAM
// model (write needs W cycles of stable we_n/address) and a word-level model.
module tb_sram_mem_stage;

  localparam int          W    = 2;
  localparam int unsigned BASE = 1024;
  localparam int          NHW  = 262144;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n;

  int tests = 0;
  int fails = 0;

  logic [15:0] sram_mem [0:NHW-1];
  logic [15:0] ref_mem  [0:NHW-1];
  logic [31:0] ref_rdata;
  logic        sram_oe;
  logic [17:0] wr_addr_prev;
  logic        wr_low_prev = 1'b0;
  int          wr_run = 0;

  always #5 clk = ~clk;

  sram_mem_stage #(
    .MEM_BASE  (BASE),
    .SRAM_WAIT (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_r_en  (mem_r_en),
    .mem_w_en  (mem_w_en),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_we_n (sram_we_n)
  );

  // SRAM chip: output enable tied to an active load, combinational read
  assign sram_dq = (sram_oe && sram_we_n) ? sram_mem[sram_addr] : 16'bz;

  // A write only lands once we_n has been low on one address for W cycles
  always @(posedge clk) begin : sram_write
    int n;
    if (!sram_we_n) begin
      n = (wr_low_prev && sram_addr == wr_addr_prev) ? wr_run + 1 : 1;
      if (n == W) sram_mem[sram_addr] = sram_dq;
      wr_run       = n;
      wr_low_prev  = 1'b1;
      wr_addr_prev = sram_addr;
    end else begin
      wr_low_prev = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) / 4;
    return off[16:0];
  endfunction

  // One access starting in an IDLE cycle; returns at the DONE cycle's negedge
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int rlow, output int wlow,
                        output logic [17:0] a_lo, output logic [17:0] a_hi);
    logic        is_w;
    logic        h;
    logic [16:0] wd;
    logic [31:0] exp_r;
    is_w = w;
    wd   = word_of(a);
    if (!is_w) ref_rdata = {ref_mem[{wd, 1'b1}], ref_mem[{wd, 1'b0}]};
    exp_r = ref_rdata;
    rlow  = 0;
    wlow  = 0;
    a_lo  = '0;
    a_hi  = '0;
    step();
    mem_r_en = r;
    mem_w_en = w;
    addr     = a;
    wdata    = d;
    sram_oe  = r & ~w;
    for (int k = 0; k <= 2*W+1; k++) begin
      @(negedge clk);
      if (!ready) rlow++;
      if (!sram_we_n) wlow++;
      chk("ready", {31'd0, ready}, {31'd0, k == 2*W+1});
      chk("we_n", {31'd0, sram_we_n}, {31'd0, !(is_w && k >= 1 && k <= 2*W)});
      if (k >= 1 && k <= 2*W) begin
        h = (k > W);
        chk("sram_addr", {14'd0, sram_addr}, {14'd0, wd, h});
        if (k == 1) a_lo = sram_addr;
        if (k == W+1) a_hi = sram_addr;
        if (is_w) chk("dq_wr", {16'd0, sram_dq}, {16'd0, h ? d[31:16] : d[15:0]});
      end
      if (k == 2*W+1) chk("rdata", rdata, exp_r);
      if (k < 2*W+1) step();
    end
    if (is_w) begin
      ref_mem[{wd, 1'b0}] = d[15:0];
      ref_mem[{wd, 1'b1}] = d[31:16];
    end
    $display("[TB] %s addr=%h wdata=%h rdata=%h stall=%0d", is_w ? "STR" : "LDR", a, d, rdata, rlow);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      sram_oe  = 1'b0;
      @(negedge clk);
      chk("idle_ready", {31'd0, ready}, 32'd1);
      chk("idle_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("idle_rdata", rdata, ref_rdata);
    end
  endtask

  initial begin : main
    int          rl, wl;
    logic [17:0] alo, ahi;
    logic [31:0] ra, rd;
    logic [16:0] wd;
    logic [15:0] old_hi;
    int          kind;

    for (int i = 0; i < NHW; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; addr = '0; wdata = '0; sram_oe = 1'b0;
    step(); step();
    rst = 1'b0;
    ref_rdata = '0;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);

    access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, rl, wl, alo, ahi);
    chk("str_stall", rl, 32'd5);
    chk("str_we_cycles", wl, 32'd4);
    chk("sram0", {16'd0, sram_mem[0]}, 32'h0000_BEEF);
    chk("sram1", {16'd0, sram_mem[1]}, 32'h0000_DEAD);

    access(1'b1, 1'b0, 32'd1024, 32'd0, rl, wl, alo, ahi);
    chk("ldr_rdata", rdata, 32'hDEAD_BEEF);
    chk("ldr_stall", rl, 32'd5);
    chk("ldr_we_cycles", wl, 32'd0);

    access(1'b1, 1'b0, 32'd1030, 32'd0, rl, wl, alo, ahi);
    chk("ldr1030_lo", {14'd0, alo}, 32'd2);
    chk("ldr1030_hi", {14'd0, ahi}, 32'd3);

    access(1'b0, 1'b1, 32'd1028, 32'h1111_2222, rl, wl, alo, ahi);
    access(1'b0, 1'b1, 32'd1032, 32'h3333_4444, rl, wl, alo, ahi);
    access(1'b1, 1'b0, 32'd1028, 32'd0, rl, wl, alo, ahi);
    chk("b2b_ld1028", rdata, 32'h1111_2222);
    access(1'b1, 1'b0, 32'd1032, 32'd0, rl, wl, alo, ahi);
    chk("b2b_ld1032", rdata, 32'h3333_4444);
    idle(2);

    // Reset during the first cycle of the high phase of a store
    ra = 32'd1040;
    rd = 32'hCAFE_F00D;
    wd = word_of(ra);
    old_hi = ref_mem[{wd, 1'b1}];
    step();
    mem_r_en = 1'b0; mem_w_en = 1'b1; addr = ra; wdata = rd; sram_oe = 1'b0;
    step(); step(); step();
    rst = 1'b1; mem_w_en = 1'b0;
    @(negedge clk);
    chk("hi_we_n_low", {31'd0, sram_we_n}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rstmid_ready", {31'd0, ready}, 32'd1);
    chk("rstmid_rdata", rdata, 32'd0);
    chk("rstmid_hi_kept", {16'd0, sram_mem[{wd, 1'b1}]}, {16'd0, old_hi});
    chk("rstmid_lo_done", {16'd0, sram_mem[{wd, 1'b0}]}, {16'd0, rd[15:0]});
    ref_mem[{wd, 1'b0}] = rd[15:0];
    ref_rdata = '0;
    $display("[TB] RST during HI of STR addr=%h", ra);

    access(1'b1, 1'b0, ra, 32'd0, rl, wl, alo, ahi);
    chk("partial_word", rdata, {old_hi, rd[15:0]});
    access(1'b1, 1'b1, 32'd1100, 32'h5A5A_A5A5, rl, wl, alo, ahi);
    chk("both_is_write", wl, 32'd4);
    access(1'b1, 1'b0, 32'd1100, 32'd0, rl, wl, alo, ahi);
    chk("both_readback", rdata, 32'h5A5A_A5A5);

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 3);
      ra = ($urandom_range(0, 9) == 0) ? $urandom : BASE + $urandom_range(0, 255);
      rd = $urandom;
      if (kind == 0 || kind == 3)
        access(1'b1, 1'b0, ra, rd, rl, wl, alo, ahi);
      else
        access(kind == 2, 1'b1, ra, rd, rl, wl, alo, ahi);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
